// File: rtl/immgen_pipe.sv
// rtl/immgen_pipe.sv - RV32I immediate generator behind a 2-entry skid buffer
module immgen_pipe #(
  parameter int XLEN        = 32,
  parameter bit EN_CSR_ZIMM = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_inst,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_imm,
  output logic [2:0]      o_imm_type,
  output logic            o_illegal
);

  localparam logic [2:0] T_NONE = 3'd0;
  localparam logic [2:0] T_I    = 3'd1;
  localparam logic [2:0] T_S    = 3'd2;
  localparam logic [2:0] T_B    = 3'd3;
  localparam logic [2:0] T_U    = 3'd4;
  localparam logic [2:0] T_J    = 3'd5;
  localparam logic [2:0] T_Z    = 3'd6;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

  state_t state, state_next;

  logic               in_xfer, out_xfer;
  logic               ready_q;
  logic               load_out_dec, load_out_skid, load_skid;

  logic [2:0]         dec_type;
  logic               dec_ill;
  logic signed [31:0] dec_imm32;
  logic [XLEN-1:0]    dec_imm;

  logic [XLEN-1:0]    out_imm, skid_imm;
  logic [2:0]         out_type, skid_type;
  logic               out_ill, skid_ill;

  assign o_ready  = ready_q;
  assign o_valid  = (state != S_EMPTY);
  assign in_xfer  = i_valid && ready_q;
  assign out_xfer = o_valid && i_ready;

  // Classify the opcode into an immediate type or flag it illegal.
  always_comb begin
    dec_type = T_NONE;
    dec_ill  = 1'b0;
    if (i_inst[1:0] != 2'b11) begin
      dec_ill = 1'b1;
    end else begin
      case (i_inst[6:2])
        5'b00100, 5'b00000, 5'b11001, 5'b00011: dec_type = T_I;
        5'b01000:                               dec_type = T_S;
        5'b11000:                               dec_type = T_B;
        5'b11011:                               dec_type = T_J;
        5'b01101, 5'b00101:                     dec_type = T_U;
        5'b01100:                               dec_type = T_NONE;
        5'b11100: dec_type = (i_inst[14] && EN_CSR_ZIMM) ? T_Z : T_I;
        default:                                dec_ill  = 1'b1;
      endcase
    end
  end

  // Assemble the 32-bit immediate, then sign-extend to XLEN (Z is non-negative).
  always_comb begin
    dec_imm32 = '0;
    case (dec_type)
      T_I: dec_imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
      T_S: dec_imm32 = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
      T_B: dec_imm32 = {{19{i_inst[31]}}, i_inst[31], i_inst[7],
                        i_inst[30:25], i_inst[11:8], 1'b0};
      T_J: dec_imm32 = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12],
                        i_inst[20], i_inst[30:21], 1'b0};
      T_U: dec_imm32 = {i_inst[31:12], 12'b0};
      T_Z: dec_imm32 = {27'b0, i_inst[19:15]};
      default: dec_imm32 = '0;
    endcase
    dec_imm = XLEN'(dec_imm32);
  end

  // Buffer state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_EMPTY;
    else          state <= state_next;
  end

  // Next-state and load-enable selection for the skid buffer.
  always_comb begin
    state_next    = state;
    load_out_dec  = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    case (state)
      S_EMPTY: begin
        if (in_xfer) begin
          state_next   = S_ONE;
          load_out_dec = 1'b1;
        end
      end
      S_ONE: begin
        if (in_xfer && out_xfer) begin
          load_out_dec = 1'b1;
        end else if (in_xfer) begin
          state_next = S_FULL;
          load_skid  = 1'b1;
        end else if (out_xfer) begin
          state_next = S_EMPTY;
        end
      end
      S_FULL: begin
        if (out_xfer) begin
          state_next    = S_ONE;
          load_out_skid = 1'b1;
        end
      end
      default: state_next = S_EMPTY;
    endcase
    if (i_flush) begin
      state_next    = S_EMPTY;
      load_out_dec  = 1'b0;
      load_out_skid = 1'b0;
      load_skid     = 1'b0;
    end
  end

  // Ready is registered from the next state so i_ready never reaches o_ready combinationally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) ready_q <= 1'b1;
    else          ready_q <= (state_next != S_FULL);
  end

  // OUT and SKID payload registers; flush clears them like reset does.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_imm   <= '0;
      out_type  <= T_NONE;
      out_ill   <= 1'b0;
      skid_imm  <= '0;
      skid_type <= T_NONE;
      skid_ill  <= 1'b0;
    end else if (i_flush) begin
      out_imm   <= '0;
      out_type  <= T_NONE;
      out_ill   <= 1'b0;
      skid_imm  <= '0;
      skid_type <= T_NONE;
      skid_ill  <= 1'b0;
    end else begin
      if (load_out_dec) begin
        out_imm  <= dec_imm;
        out_type <= dec_type;
        out_ill  <= dec_ill;
      end else if (load_out_skid) begin
        out_imm  <= skid_imm;
        out_type <= skid_type;
        out_ill  <= skid_ill;
      end
      if (load_skid) begin
        skid_imm  <= dec_imm;
        skid_type <= dec_type;
        skid_ill  <= dec_ill;
      end
    end
  end

  assign o_imm      = out_imm;
  assign o_imm_type = out_type;
  assign o_illegal  = out_ill;

endmodule

// File: tb/tb_immgen_pipe.sv
// tb/tb_immgen_pipe.sv - directed self-checking bench for immgen_pipe
module tb_immgen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] inst;
  logic        out_ready;

  logic        ready32, valid32, ill32;
  logic [31:0] imm32;
  logic [2:0]  type32;

  logic        ready64, valid64, ill64;
  logic [63:0] imm64;
  logic [2:0]  type64;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  immgen_pipe #(.XLEN(32), .EN_CSR_ZIMM(1'b1)) dut32 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(in_valid),
    .o_ready(ready32), .i_inst(inst), .o_valid(valid32), .i_ready(out_ready),
    .o_imm(imm32), .o_imm_type(type32), .o_illegal(ill32)
  );

  immgen_pipe #(.XLEN(64), .EN_CSR_ZIMM(1'b1)) dut64 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(in_valid),
    .o_ready(ready64), .i_inst(inst), .o_valid(valid64), .i_ready(out_ready),
    .o_imm(imm64), .o_imm_type(type64), .o_illegal(ill64)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] e_imm, input logic [2:0] e_type,
                         input logic e_ill);
    chk({tag, "_valid"}, 64'(valid32), 64'd1);
    chk({tag, "_imm"},   64'(imm32),   64'(e_imm));
    chk({tag, "_type"},  64'(type32),  64'(e_type));
    chk({tag, "_ill"},   64'(ill32),   64'(e_ill));
    chk({tag, "_imm64"}, imm64,        {{32{e_imm[31]}}, e_imm});
    chk({tag, "_type64"}, 64'(type64), 64'(e_type));
  endtask

  logic [31:0] v_inst [10] = '{32'hFFF00093, 32'h800002B7, 32'h00112623, 32'hFE000EE3,
                               32'h008000EF, 32'h3401D073, 32'h34011073, 32'h00208033,
                               32'h00000000, 32'h0000007F};
  logic [31:0] v_imm  [10] = '{32'hFFFFFFFF, 32'h80000000, 32'h0000000C, 32'hFFFFFFFC,
                               32'h00000008, 32'h00000003, 32'h00000340, 32'h00000000,
                               32'h00000000, 32'h00000000};
  logic [2:0]  v_type [10] = '{3'd1, 3'd4, 3'd2, 3'd3, 3'd5, 3'd6, 3'd1, 3'd0, 3'd0, 3'd0};
  logic        v_ill  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    inst      = 32'h0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(valid32), 64'd0);
    chk("rst_ready", 64'(ready32), 64'd1);
    chk("rst_imm",   64'(imm32),   64'd0);
    chk("rst_type",  64'(type32),  64'd0);
    chk("rst_ill",   64'(ill32),   64'd0);
    chk("rst_imm64", imm64,        64'd0);
    rst_n = 1'b1;

    // Streaming at full rate: each entry appears one cycle after its transfer.
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      inst     = v_inst[i];
      step();
      chk_out($sformatf("stream%0d", i), v_imm[i], v_type[i], v_ill[i]);
      chk($sformatf("stream%0d_ready", i), 64'(ready32), 64'd1);
    end
    in_valid = 1'b0;
    step();
    chk("drain_valid", 64'(valid32), 64'd0);

    // Backpressure fills the skid buffer; order and stability are preserved.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    inst      = 32'hFE000EE3;
    step();
    chk_out("bp_first", 32'hFFFFFFFC, 3'd3, 1'b0);
    chk("bp_first_ready", 64'(ready32), 64'd1);
    inst = 32'h3401D073;
    step();
    chk("bp_full_ready", 64'(ready32), 64'd0);
    chk_out("bp_stable", 32'hFFFFFFFC, 3'd3, 1'b0);
    inst = 32'hFFF00093;
    step();
    chk("bp_held_ready", 64'(ready32), 64'd0);
    chk_out("bp_stable2", 32'hFFFFFFFC, 3'd3, 1'b0);
    out_ready = 1'b1;
    step();
    chk_out("bp_second", 32'h00000003, 3'd6, 1'b0);
    chk("bp_reopen_ready", 64'(ready32), 64'd1);
    step();
    chk_out("bp_third", 32'hFFFFFFFF, 3'd1, 1'b0);
    in_valid = 1'b0;
    step();
    chk("bp_empty", 64'(valid32), 64'd0);

    // Flush from FULL discards both held entries and the concurrent input.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    inst      = 32'hFE000EE3;
    step();
    inst = 32'h3401D073;
    step();
    chk("fl_full_ready", 64'(ready32), 64'd0);
    flush = 1'b1;
    inst  = 32'h800002B7;
    step();
    chk("fl_valid", 64'(valid32), 64'd0);
    chk("fl_ready", 64'(ready32), 64'd1);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("fl_valid2", 64'(valid32), 64'd0);
    step();
    chk("fl_valid3", 64'(valid32), 64'd0);

    // Asynchronous reset pulse between edges while FULL.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    inst      = 32'hFE000EE3;
    step();
    inst = 32'h3401D073;
    step();
    chk("ar_full_ready", 64'(ready32), 64'd0);
    in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 64'(valid32), 64'd0);
    chk("ar_ready", 64'(ready32), 64'd1);
    chk("ar_imm",   64'(imm32),   64'd0);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    inst      = 32'hFFF00093;
    step();
    chk_out("ar_addi", 32'hFFFFFFFF, 3'd1, 1'b0);
    in_valid = 1'b0;
    step();
    chk("ar_empty", 64'(valid32), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/immgen_pipe.md
IMMGEN_PIPE -- requirements
Module: immgen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, output immediate width; legal values 32 or 64.
REQ-002 SHALL have parameter EN_CSR_ZIMM, default 1, enables the zero-extended CSR immediate type.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 SHALL have i_clk, input, 1, clock; all state updates on its rising edge.
REQ-005 SHALL have i_rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have i_flush, input, 1, synchronous discard of all held entries.
REQ-007 SHALL have i_valid, input, 1, upstream instruction valid.
REQ-008 SHALL have o_ready, output, 1, block can accept an instruction.
REQ-009 SHALL have i_inst, input, 32, instruction word.
REQ-010 SHALL have o_valid, output, 1, output entry valid.
REQ-011 SHALL have i_ready, input, 1, downstream accepts the output entry.
REQ-012 SHALL have o_imm, output, XLEN, sign/zero-extended immediate.
REQ-013 SHALL have o_imm_type, output, 3, immediate type: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z.
REQ-014 SHALL have o_illegal, output, 1, instruction not decodable.

Function
REQ-015 SHALL decode opcode i_inst[6:2] as follows; i_inst[1:0] must equal 2'b11.
- 00100, 00000, 11001, 00011: I-type.
- 01000: S-type.
- 11000: B-type.
- 11011: J-type.
- 01101, 00101: U-type.
- 01100: NONE.
- 11100: Z-type when i_inst[14] is 1 and EN_CSR_ZIMM is 1, otherwise I-type.
REQ-016 SHALL form the immediate fields per RV32I.
- I: inst[31:20].
- S: {inst[31:25], inst[11:7]}.
- B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
- J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
- U: {inst[31:12], 12'b0}.
REQ-017 SHALL sign-extend I/S/B/J/U from inst[31] to XLEN; U-type is also sign-extended when XLEN is 64.
REQ-018 SHALL zero-extend Z-type inst[19:15] to XLEN.
REQ-019 For type NONE, o_imm SHALL be 0 and o_illegal 0.
REQ-020 If i_inst[1:0] is not 2'b11 or the opcode is unlisted, the block SHALL set o_illegal to 1, o_imm to 0 and o_imm_type to NONE.
REQ-021 An input transfer SHALL occur when i_valid and o_ready are both 1 at a rising edge; an output transfer when o_valid and i_ready are both 1.
REQ-022 Latency SHALL be exactly 1 cycle: a decoded entry appears on the outputs the cycle after its input transfer when the output register is empty or draining.
REQ-023 SHALL hold entries in a 2-entry skid buffer: output register OUT plus SKID register.
REQ-024 Buffer states SHALL be EMPTY (no entries), ONE (OUT valid) and FULL (OUT and SKID valid).
REQ-025 Transitions SHALL be:
- EMPTY -> ONE on input transfer.
- ONE -> EMPTY on output transfer with no input.
- ONE -> ONE on simultaneous input and output transfer; OUT is replaced.
- ONE -> FULL on input transfer with no output transfer; the new entry goes to SKID.
- FULL -> ONE on output transfer; SKID moves to OUT.
REQ-026 o_ready SHALL be a registered signal equal to 1 when not FULL; there SHALL be no combinational path from i_ready to o_ready.
REQ-027 While o_valid is 1 and i_ready is 0, o_imm, o_imm_type and o_illegal SHALL remain stable.
REQ-028 Entries SHALL leave in input order; none is dropped or duplicated outside flush and reset.
REQ-029 On i_flush, the next state SHALL be EMPTY.
- Flush has priority over a simultaneous input transfer, which is discarded.
- Flush has priority over a simultaneous output transfer, which counts as consumed.
REQ-030 Illegal instructions SHALL flow through the buffer like any other entry.

Reset
REQ-031 While i_rst_n is 0, the block SHALL be in state EMPTY with:
- o_valid 0, o_ready 1;
- o_imm 0, o_imm_type 0, o_illegal 0;
- SKID contents cleared.
REQ-032 Reset assertion mid-transfer SHALL drop all held entries asynchronously; after release the block SHALL accept input on the first edge.

Verification
REQ-033 XLEN=32, send 0xFFF00093 (ADDI x1,x0,-1), i_ready=1 -> next cycle o_valid=1, o_imm=0xFFFFFFFF, o_imm_type=1, o_illegal=0.
REQ-034 XLEN=64, send 0x800002B7 (LUI) -> o_imm=0xFFFFFFFF80000000, o_imm_type=4.
REQ-035 i_ready=0, send 0xFE000EE3 (BEQ) then 0x3401D073 (CSRRWI zimm 3), third i_valid held -> o_ready=0 after the second transfer.
- Raise i_ready: outputs in order are imm 0xFFFFFFFC type 3, then imm 0x3 type 6.
- Only then is the third entry accepted.
REQ-036 Send 0x00000000 and 0x0000007F -> each yields o_illegal=1, o_imm=0, o_imm_type=0.
REQ-037 In state FULL, assert i_flush with i_valid=1 -> next cycle o_valid=0, o_ready=1; no entry from before or during the flush ever appears.
REQ-038 In state FULL, pulse i_rst_n low between edges -> o_valid=0 immediately; after release, a new ADDI is decoded with 1-cycle latency.
